ee354_gcd_driver: RTL and testbench

Hardware initiator for the ee354 GCD core's Start/Done/Ack handshake. It sweeps every operand pair (Ain, Bin) over a parameterised range, pulses Start, waits for the core to finish, measures the compute time, pulses Ack, and publishes each result on a one-cycle result strobe. It sits beside the GCD core in the top-level design, replacing manual push-button Start/Ack for on-board regression sweeps.

---
 rtl/ee354_gcd_driver_pkg.sv | 21 ++
 rtl/ee354_gcd_driver_if.sv | 17 +
 rtl/ee354_gcd_operand_seq.sv | 44 ++++
 rtl/ee354_gcd_driver.sv | 164 ++++++++++++++++
 tb/tb_ee354_gcd_driver.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ee354_gcd_driver_pkg.sv
// Shared definitions for the ee354 GCD sweep driver: one-hot state names and
// the default operand range and wait-state timeout.
package ee354_gcd_driver_pkg;

  localparam int LO_DEFAULT      = 2;
  localparam int HI_DEFAULT      = 63;
  localparam int TIMEOUT_DEFAULT = 1023;
  localparam int NUM_STATES      = 8;

  typedef enum logic [NUM_STATES-1:0] {
    D_IDLE      = 8'b0000_0001,
    D_START     = 8'b0000_0010,
    D_WAIT_SUB  = 8'b0000_0100,
    D_WAIT_DONE = 8'b0000_1000,
    D_ACK       = 8'b0001_0000,
    D_WAIT_I    = 8'b0010_0000,
    D_FIN       = 8'b0100_0000,
    D_ERR       = 8'b1000_0000
  } drv_state_t;

endpackage

// File: rtl/ee354_gcd_driver_if.sv
// Start/Done/Ack handshake bundle between the sweep driver (master) and the
// ee354 GCD core (slave).
interface ee354_gcd_driver_if #(
  parameter int W = 8
);
  logic [W-1:0] Ain;
  logic [W-1:0] Bin;
  logic [W-1:0] AB_GCD;
  logic         Start;
  logic         Ack;
  logic         q_I;
  logic         q_Sub;
  logic         q_Done;

  modport master (output Ain, Bin, Start, Ack, input q_I, q_Sub, q_Done, AB_GCD);
  modport slave  (input Ain, Bin, Start, Ack, output q_I, q_Sub, q_Done, AB_GCD);
endinterface

// File: rtl/ee354_gcd_operand_seq.sv
// Nested LO..HI operand counter: Bin is the inner loop, Ain the outer loop.
// init loads (LO, LO); step advances one pair; last flags (HI, HI).
module ee354_gcd_operand_seq
  import ee354_gcd_driver_pkg::*;
#(
  parameter int W  = 8,
  parameter int LO = LO_DEFAULT,
  parameter int HI = HI_DEFAULT
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         CEN,
  input  logic         init,
  input  logic         step,
  output logic [W-1:0] Ain,
  output logic [W-1:0] Bin,
  output logic         last
);

  localparam logic [W-1:0] LO_V = W'(LO);
  localparam logic [W-1:0] HI_V = W'(HI);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Ain <= '0;
      Bin <= '0;
    end else if (CEN) begin
      if (init) begin
        Ain <= LO_V;
        Bin <= LO_V;
      end else if (step) begin
        if (Bin != HI_V) begin
          Bin <= Bin + W'(1);
        end else begin
          Bin <= LO_V;
          if (Ain != HI_V) Ain <= Ain + W'(1);
        end
      end
    end
  end

  assign last = (Ain == HI_V) && (Bin == HI_V);

endmodule

// File: rtl/ee354_gcd_driver.sv
// Sweep driver for the ee354 GCD core: walks every (Ain, Bin) pair, times each
// computation and strobes the result. GCD_DRV_STATS_EN adds sweep statistics.
module ee354_gcd_driver
  import ee354_gcd_driver_pkg::*;
#(
  parameter int LO      = LO_DEFAULT,
  parameter int HI      = HI_DEFAULT,
  parameter int W       = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          CEN,
  input  logic          Go,
  ee354_gcd_driver_if.master core,
  output logic          res_valid,
  output logic [W-1:0]  res_A,
  output logic [W-1:0]  res_B,
  output logic [W-1:0]  res_GCD,
  output logic [CW-1:0] res_clocks,
  output logic          busy,
  output logic          sweep_done,
  output logic          err
`ifdef GCD_DRV_STATS_EN
  ,
  output logic [CW-1:0] stat_pairs,
  output logic [CW-1:0] stat_max_clocks
`endif
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  drv_state_t     state, state_n;
  logic [CW-1:0]  cnt;
  logic [WCW-1:0] wait_cnt;
  logic [W-1:0]   ain, bin;
  logic           seq_init, seq_step, seq_last, wait_expired, latch, in_wait;

  ee354_gcd_operand_seq #(.W(W), .LO(LO), .HI(HI)) u_seq (
    .Clk   (Clk),
    .Reset (Reset),
    .CEN   (CEN),
    .init  (seq_init),
    .step  (seq_step),
    .Ain   (ain),
    .Bin   (bin),
    .last  (seq_last)
  );

  assign wait_expired = (wait_cnt == WCW'(TIMEOUT - 1));
  assign in_wait      = (state == D_WAIT_SUB) || (state == D_WAIT_DONE) || (state == D_WAIT_I);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)    state <= D_IDLE;
    else if (CEN) state <= state_n;
  end

  always_comb begin
    state_n  = state;
    seq_init = 1'b0;
    seq_step = 1'b0;
    latch    = 1'b0;
    unique case (state)
      D_IDLE, D_FIN: begin
        if (Go) begin
          seq_init = 1'b1;
          state_n  = D_START;
        end
      end
      D_START: state_n = D_WAIT_SUB;
      D_WAIT_SUB: begin
        if (core.q_Sub)        state_n = D_WAIT_DONE;
        else if (wait_expired) state_n = D_ERR;
      end
      D_WAIT_DONE: begin
        if (core.q_Done) begin
          latch   = 1'b1;
          state_n = D_ACK;
        end else if (wait_expired) begin
          state_n = D_ERR;
        end
      end
      D_ACK: state_n = D_WAIT_I;
      D_WAIT_I: begin
        if (core.q_I) begin
          if (seq_last) begin
            state_n = D_FIN;
          end else begin
            seq_step = 1'b1;
            state_n  = D_START;
          end
        end else if (wait_expired) begin
          state_n = D_ERR;
        end
      end
      D_ERR:   state_n = D_ERR;
      default: state_n = D_IDLE;
    endcase
  end

  // The wait counter restarts on every state change, so it only accumulates
  // while the driver sits in one of the three wait states.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (CEN) begin
      if (state_n != state) wait_cnt <= '0;
      else if (in_wait)     wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (CEN) begin
      if (state == D_WAIT_SUB && core.q_Sub)
        cnt <= '0;
      else if (state == D_WAIT_DONE && !core.q_Done && cnt != '1)
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      res_A      <= '0;
      res_B      <= '0;
      res_GCD    <= '0;
      res_clocks <= '0;
    end else if (CEN && latch) begin
      res_A      <= ain;
      res_B      <= bin;
      res_GCD    <= core.AB_GCD;
      res_clocks <= cnt;
    end
  end

`ifdef GCD_DRV_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stat_pairs      <= '0;
      stat_max_clocks <= '0;
    end else if (CEN) begin
      if (seq_init) begin
        stat_pairs      <= '0;
        stat_max_clocks <= '0;
      end else if (latch) begin
        stat_pairs <= stat_pairs + CW'(1);
        if (cnt > stat_max_clocks) stat_max_clocks <= cnt;
      end
    end
  end
`endif

  assign core.Ain   = ain;
  assign core.Bin   = bin;
  assign core.Start = (state == D_START);
  assign core.Ack   = (state == D_ACK);
  assign res_valid  = (state == D_ACK);
  assign busy       = !((state == D_IDLE) || (state == D_FIN) || (state == D_ERR));
  assign sweep_done = (state == D_FIN);
  assign err        = (state == D_ERR);

endmodule

// File: tb/tb_ee354_gcd_driver.sv
// Bench for ee354_gcd_driver with a behavioural GCD core and a sweep-order
// scoreboard; also covers timeout, CEN freeze, saturation and mid-sweep reset.
module tb_ee354_gcd_driver;

  localparam int LO      = 2;
  localparam int HI      = 3;
  localparam int W       = 8;
  localparam int CW      = 4;
  localparam int TIMEOUT = 50;
  localparam int N       = HI - LO + 1;
  localparam int CMAX    = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset, CEN, Go;
  logic          res_valid, busy, sweep_done, err;
  logic [W-1:0]  res_A, res_B, res_GCD;
  logic [CW-1:0] res_clocks;
`ifdef GCD_DRV_STATS_EN
  logic [CW-1:0] stat_pairs, stat_max_clocks;
`endif

  ee354_gcd_driver_if #(.W(W)) gif ();

  ee354_gcd_driver #(.LO(LO), .HI(HI), .W(W), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .CEN        (CEN),
    .Go         (Go),
    .core       (gif),
    .res_valid  (res_valid),
    .res_A      (res_A),
    .res_B      (res_B),
    .res_GCD    (res_GCD),
    .res_clocks (res_clocks),
    .busy       (busy),
    .sweep_done (sweep_done),
    .err        (err)
`ifdef GCD_DRV_STATS_EN
    ,
    .stat_pairs      (stat_pairs),
    .stat_max_clocks (stat_max_clocks)
`endif
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check_output(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endfunction

  function automatic int gcd_of(input int a, input int b);
    int x, y;
    x = a;
    y = b;
    if (x == 0 || y == 0) return x + y;
    while (x != y) begin
      if (x > y) x -= y;
      else       y -= x;
    end
    return x;
  endfunction

  function automatic int steps_of(input int a, input int b);
    int x, y, s;
    x = a;
    y = b;
    s = 0;
    if (x == 0 || y == 0) return 0;
    while (x != y) begin
      if (x > y) x -= y;
      else       y -= x;
      s++;
    end
    return s;
  endfunction

  // Behavioural core: I -> SUB on Start, stays in SUB for a set number of
  // enabled cycles, DONE until Ack. Shares CEN with the driver.
  typedef enum int {C_I, C_SUB, C_DONE} core_st_t;
  core_st_t     core_st;
  int           sub_left;
  int           core_sub_seen;
  logic [W-1:0] gcd_r;
  int           fixed_len = 0;
  bit           hang = 1'b0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      core_st       <= C_I;
      sub_left      <= 0;
      core_sub_seen <= 0;
      gcd_r         <= '0;
    end else if (CEN) begin
      case (core_st)
        C_I: if (gif.Start) begin
          core_st       <= C_SUB;
          sub_left      <= ((fixed_len > 0) ? fixed_len : 2 + steps_of(int'(gif.Ain), int'(gif.Bin))) - 1;
          core_sub_seen <= 0;
          gcd_r         <= W'(gcd_of(int'(gif.Ain), int'(gif.Bin)));
        end
        C_SUB: begin
          core_sub_seen <= core_sub_seen + 1;
          if (sub_left == 0) begin
            if (!hang) core_st <= C_DONE;
          end else begin
            sub_left <= sub_left - 1;
          end
        end
        C_DONE: if (gif.Ack) core_st <= C_I;
        default: core_st <= C_I;
      endcase
    end
  end

  assign gif.q_I    = (core_st == C_I);
  assign gif.q_Sub  = (core_st == C_SUB);
  assign gif.q_Done = (core_st == C_DONE);
  assign gif.AB_GCD = gcd_r;

  bit prev_en = 1'b0;
  always @(posedge Clk) prev_en <= CEN;

  // Scoreboard state: strobe k of a sweep must carry pair (LO + k/N, LO + k%N).
  int sweep_gen = 0;
  int seen_gen = 0;
  int strobe_k = 0;
  int max_exp = 0;
  int start_total = 0;
  int start_run = 0;
  int ack_run = 0;
  int log_A[$];
  int log_B[$];
  int log_G[$];
  int log_C[$];

  always @(negedge Clk) begin : compare
    int kk, ea, eb, ec;
    if (Reset) begin
      start_run <= 0;
      ack_run   <= 0;
    end else if (prev_en) begin
      if (gif.Start) begin
        check_output("start_while_core_busy", gif.q_I, 1);
        start_run   <= start_run + 1;
        start_total <= start_total + 1;
      end else begin
        if (start_run != 0) check_output("start_width", start_run, 1);
        start_run <= 0;
      end
      if (gif.Ack) begin
        ack_run <= ack_run + 1;
      end else begin
        if (ack_run != 0) check_output("ack_width", ack_run, 1);
        ack_run <= 0;
      end
      if (res_valid) begin
        kk = (seen_gen == sweep_gen) ? strobe_k : 0;
        ea = LO + kk / N;
        eb = LO + kk % N;
        ec = (core_sub_seen - 1 > CMAX) ? CMAX : core_sub_seen - 1;
        check_output("strobe_in_sweep", longint'(kk < N * N), 1);
        check_output("res_A", res_A, ea);
        check_output("res_B", res_B, eb);
        check_output("res_GCD", res_GCD, gcd_of(ea, eb));
        check_output("res_clocks", res_clocks, ec);
        check_output("ack_with_strobe", gif.Ack, 1);
        log_A.push_back(int'(res_A));
        log_B.push_back(int'(res_B));
        log_G.push_back(int'(res_GCD));
        log_C.push_back(int'(res_clocks));
        strobe_k <= kk + 1;
        seen_gen <= sweep_gen;
        max_exp  <= (seen_gen == sweep_gen && max_exp > ec) ? max_exp : ec;
      end
    end
  end

  function automatic int cur_strobes();
    return (seen_gen == sweep_gen) ? strobe_k : 0;
  endfunction

  int log_base = 0;
  int start_base = 0;

  task automatic apply_stimulus(input int len, input bit hang_mode);
    fixed_len  = len;
    hang       = hang_mode;
    log_base   = log_A.size();
    start_base = start_total;
    sweep_gen++;
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
  endtask

  task automatic wait_sweep(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (sweep_done) break;
      @(negedge Clk);
    end
    check_output(name, sweep_done, 1);
  endtask

  task automatic wait_core_sub(input int min_seen, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (core_st == C_SUB && core_sub_seen >= min_seen) begin
        found = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    check_output(name, found, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_Start"}, gif.Start, 0);
    check_output({tag, "_Ack"}, gif.Ack, 0);
    check_output({tag, "_res_valid"}, res_valid, 0);
    check_output({tag, "_Ain"}, gif.Ain, 0);
    check_output({tag, "_Bin"}, gif.Bin, 0);
    check_output({tag, "_res_A"}, res_A, 0);
    check_output({tag, "_res_GCD"}, res_GCD, 0);
    check_output({tag, "_res_clocks"}, res_clocks, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_sweep_done"}, sweep_done, 0);
    check_output({tag, "_err"}, err, 0);
  endtask

  task automatic check_all_clocks(input string name, input int exp);
    check_output({name, "_count"}, cur_strobes(), N * N);
    for (int i = 0; i < N * N; i++) check_output(name, log_C[log_base + i], exp);
    check_output({name, "_starts"}, start_total - start_base, N * N);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int exp_a[4] = '{2, 2, 3, 3};
    int exp_b[4] = '{2, 3, 2, 3};
    int exp_g[4] = '{2, 1, 1, 3};
    int exp_c[4] = '{1, 3, 3, 1};
    Reset = 1'b1;
    CEN   = 1'b1;
    Go    = 1'b0;
    repeat (3) @(negedge Clk);
    check_idle_outputs("reset");
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check_output("idle_busy", busy, 0);

    // Sweep 1: data-dependent core latency, hand-computed strobe contents.
    apply_stimulus(0, 1'b0);
    check_output("sweep1_busy", busy, 1);
    wait_sweep("sweep1_done");
    check_output("sweep1_count", cur_strobes(), 4);
    for (int i = 0; i < 4; i++) begin
      check_output("sweep1_lit_A", log_A[log_base + i], exp_a[i]);
      check_output("sweep1_lit_B", log_B[log_base + i], exp_b[i]);
      check_output("sweep1_lit_GCD", log_G[log_base + i], exp_g[i]);
      check_output("sweep1_lit_clocks", log_C[log_base + i], exp_c[i]);
    end
    check_output("sweep1_fin_busy", busy, 0);
`ifdef GCD_DRV_STATS_EN
    check_output("stat_pairs", stat_pairs, 4);
    check_output("stat_max_model", stat_max_clocks, max_exp);
    check_output("stat_max_lit", stat_max_clocks, 3);
`endif

    // Sweep 2: restart from D_FIN, fixed 6 Sub cycles, Go pulsed mid-sweep.
    apply_stimulus(6, 1'b0);
    repeat (8) @(negedge Clk);
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    wait_sweep("sweep2_done");
    check_all_clocks("sweep2_clocks", 5);

    // Sweep 3: CEN low for 10 cycles while the driver waits for q_Done.
    apply_stimulus(6, 1'b0);
    wait_core_sub(2, "sweep3_reach_sub");
    CEN = 1'b0;
    repeat (10) @(negedge Clk);
    CEN = 1'b1;
    wait_sweep("sweep3_done");
    check_all_clocks("sweep3_clocks", 5);

    // Sweep 4: compute cycles beyond the CW-bit counter range saturate.
    apply_stimulus(21, 1'b0);
    wait_sweep("sweep4_done");
    check_all_clocks("sweep4_sat_clocks", CMAX);
`ifdef GCD_DRV_STATS_EN
    check_output("stat_max_sat", stat_max_clocks, CMAX);
    check_output("stat_pairs_sat", stat_pairs, 4);
`endif

    // Reset in D_WAIT_DONE of the second pair, then a fresh sweep.
    apply_stimulus(6, 1'b0);
    for (int i = 0; i < 500; i++) begin
      if (cur_strobes() >= 1) break;
      @(negedge Clk);
    end
    check_output("rst_first_strobe", cur_strobes(), 1);
    wait_core_sub(2, "rst_reach_sub");
    Reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    apply_stimulus(6, 1'b0);
    wait_sweep("rst_sweep_done");
    check_output("rst_restart_A", log_A[log_base], LO);
    check_output("rst_restart_B", log_B[log_base], LO);
    check_output("rst_sweep_count", cur_strobes(), 4);

    // Core never finishes: D_ERR after TIMEOUT enabled cycles in D_WAIT_DONE.
    apply_stimulus(6, 1'b1);
    wait_core_sub(0, "hang_reach_sub");
    repeat (TIMEOUT) @(negedge Clk);
    check_output("timeout_not_early", err, 0);
    @(negedge Clk);
    check_output("timeout_err", err, 1);
    check_output("timeout_busy", busy, 0);
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    repeat (3) @(negedge Clk);
    check_output("err_ignores_go", err, 1);
    check_output("err_no_start", gif.Start, 0);
    Reset = 1'b1;
    #1;
    check_output("reset_clears_err", err, 0);
    @(negedge Clk);
    Reset = 1'b0;
    hang  = 1'b0;
    repeat (2) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
